// File: rtl/fir_ctrl_pkg.sv
// Shared definitions for the FIR control path.
// Sequencer states, default widths and block geometry.
package fir_ctrl_pkg;

    localparam int DW_DEF          = 18;
    localparam int ADDR_W_DEF      = 11;
    localparam int SAMPLES_PER_BLK = 8;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/fir_cb_sequencer.sv
// Circular-buffer sequencer for the FIR datapath.
// Writes one sample, sweeps all tap blocks, then flags the result.
module fir_cb_sequencer
    import fir_ctrl_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int NBLK    = 2048,
    parameter int MAC_LAT = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              din_valid,
    input  logic [DW-1:0]     din,
    input  logic              clr_overrun,
    output logic              ready,
    output logic              cb_wen,
    output logic [DW-1:0]     cb_din,
    output logic [ADDR_W-1:0] cb_addr,
    output logic [ADDR_W-1:0] coef_addr,
    output logic              mac_en,
    output logic              mac_clr,
    output logic              mac_last,
    output logic              acc_latch,
    output logic              overrun
);

    localparam int DCW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    localparam logic [ADDR_W:0] LAST_BLK = (ADDR_W+1)'(NBLK - 1);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [DCW-1:0]  DRN_LAST = DCW'(MAC_LAT - 1);
    localparam logic [DCW-1:0]  DRN_ONE  = DCW'(1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [ADDR_W:0] r_cnt;
    logic [ADDR_W:0] w_cnt_nxt;
    logic [DCW-1:0]  r_dcnt;
    logic [DCW-1:0]  w_dcnt_nxt;
    logic            w_accept;
    logic            w_drop;
    logic            w_issue;

    assign w_accept = din_valid & ready;
    assign w_drop   = din_valid & ~ready;
    assign w_issue  = (r_state == READ);

    // Block address doubles as the sweep counter; it holds outside READ.
    assign cb_addr   = r_cnt[ADDR_W-1:0];
    assign coef_addr = r_cnt[ADDR_W-1:0];

    // Next-state and counter update for the write/sweep/drain sequence.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dcnt_nxt  = r_dcnt;
        unique case (r_state)
            IDLE: begin
                if (w_accept) w_state_nxt = WRITE;
            end
            WRITE: begin
                w_state_nxt = READ;
                w_cnt_nxt   = '0;
            end
            READ: begin
                if (r_cnt == LAST_BLK) begin
                    w_state_nxt = DRAIN;
                    w_dcnt_nxt  = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            DRAIN: begin
                if (r_dcnt == DRN_LAST) w_state_nxt = DONE;
                else                    w_dcnt_nxt  = r_dcnt + DRN_ONE;
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_dcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dcnt  <= w_dcnt_nxt;
        end
    end

    // Registered outputs; MAC strobes lag the read issue by one cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            ready     <= 1'b1;
            cb_wen    <= 1'b0;
            cb_din    <= '0;
            mac_en    <= 1'b0;
            mac_clr   <= 1'b0;
            mac_last  <= 1'b0;
            acc_latch <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            ready     <= (w_state_nxt == IDLE);
            cb_wen    <= (w_state_nxt == WRITE);
            if (w_accept) cb_din <= din;
            mac_en    <= w_issue;
            mac_clr   <= w_issue && (r_cnt == '0);
            mac_last  <= w_issue && (r_cnt == LAST_BLK);
            acc_latch <= (w_state_nxt == DONE);
            overrun   <= w_drop | (overrun & ~clr_overrun);
        end
    end

endmodule

// File: tb/tb_fir_cb_sequencer.sv
// Bench for fir_cb_sequencer: scoreboard on the NBLK=4 instance,
// directed timing checks on NBLK=1 and NBLK=2048 instances.
module tb_fir_cb_sequencer;
    import fir_ctrl_pkg::*;

    localparam int NB = 4;
    localparam int ML = 2;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;

    logic        din_valid, clr_overrun;
    logic [17:0] din;
    logic        ready, cb_wen, mac_en, mac_clr, mac_last;
    logic        acc_latch, overrun;
    logic [17:0] cb_din;
    logic [10:0] cb_addr, coef_addr;

    logic        d1_valid, d1_clr;
    logic [17:0] d1_din;
    logic        d1_ready, d1_wen, d1_en, d1_mclr, d1_last;
    logic        d1_acc, d1_ovr;
    logic [17:0] d1_cbd;
    logic [10:0] d1_addr, d1_caddr;

    logic        bg_valid, bg_clr;
    logic [17:0] bg_din;
    logic        bg_ready, bg_wen, bg_en, bg_mclr, bg_last;
    logic        bg_acc, bg_ovr;
    logic [17:0] bg_cbd;
    logic [10:0] bg_addr, bg_caddr;

    fir_cb_sequencer #(.NBLK(NB), .MAC_LAT(ML)) u_dut (
        .clock(clock), .reset(reset),
        .din_valid(din_valid), .din(din),
        .clr_overrun(clr_overrun), .ready(ready),
        .cb_wen(cb_wen), .cb_din(cb_din),
        .cb_addr(cb_addr), .coef_addr(coef_addr),
        .mac_en(mac_en), .mac_clr(mac_clr),
        .mac_last(mac_last), .acc_latch(acc_latch),
        .overrun(overrun)
    );

    fir_cb_sequencer #(.NBLK(1), .MAC_LAT(1)) u_d1 (
        .clock(clock), .reset(reset),
        .din_valid(d1_valid), .din(d1_din),
        .clr_overrun(d1_clr), .ready(d1_ready),
        .cb_wen(d1_wen), .cb_din(d1_cbd),
        .cb_addr(d1_addr), .coef_addr(d1_caddr),
        .mac_en(d1_en), .mac_clr(d1_mclr),
        .mac_last(d1_last), .acc_latch(d1_acc),
        .overrun(d1_ovr)
    );

    fir_cb_sequencer #(.NBLK(2048), .MAC_LAT(2)) u_dbig (
        .clock(clock), .reset(reset),
        .din_valid(bg_valid), .din(bg_din),
        .clr_overrun(bg_clr), .ready(bg_ready),
        .cb_wen(bg_wen), .cb_din(bg_cbd),
        .cb_addr(bg_addr), .coef_addr(bg_caddr),
        .mac_en(bg_en), .mac_clr(bg_mclr),
        .mac_last(bg_last), .acc_latch(bg_acc),
        .overrun(bg_ovr)
    );

    typedef struct {
        logic [17:0] d;
        int          c;
    } wr_t;

    typedef struct {
        int   c;
        int   k;
        logic clr;
        logic last;
    } mac_t;

    wr_t  q_wr[$];
    mac_t q_mac[$];
    int   q_acc[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int free_at = 0;
    int prev_addr = 0;
    int prev_caddr = 0;

    // One clock: scoreboard the NBLK=4 outputs mid-cycle, then advance.
    task automatic tick();
        wr_t  w;
        mac_t m;
        int   a;
        @(negedge clock);
        if (cb_wen === 1'b1) begin
            checks++;
            if (q_wr.size() == 0) begin
                errors++;
                $display("FAIL cb_wen_unexpected cyc=%0d got wen=1 want 0",
                         cyc);
            end else begin
                w = q_wr.pop_front();
                if (cb_din !== w.d || cyc !== w.c) begin
                    errors++;
                    $display("FAIL cb_write got d=%h cyc=%0d want d=%h cyc=%0d",
                             cb_din, cyc, w.d, w.c);
                end
            end
        end
        if (mac_en === 1'b1) begin
            checks++;
            if (q_mac.size() == 0) begin
                errors++;
                $display("FAIL mac_en_unexpected cyc=%0d got en=1 want 0",
                         cyc);
            end else begin
                m = q_mac.pop_front();
                if (cyc !== m.c || mac_clr !== m.clr ||
                    mac_last !== m.last || prev_addr !== m.k ||
                    prev_caddr !== m.k) begin
                    errors++;
                    $display("FAIL mac_beat got cyc=%0d clr=%b last=%b addr=%0d/%0d want cyc=%0d clr=%b last=%b addr=%0d",
                             cyc, mac_clr, mac_last, prev_addr, prev_caddr,
                             m.c, m.clr, m.last, m.k);
                end
            end
        end else if (mac_clr !== 1'b0 || mac_last !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL mac_strobe_no_en cyc=%0d got clr=%b last=%b want 0 0",
                     cyc, mac_clr, mac_last);
        end
        if (acc_latch === 1'b1) begin
            checks++;
            if (q_acc.size() == 0) begin
                errors++;
                $display("FAIL acc_unexpected cyc=%0d got 1 want 0", cyc);
            end else begin
                a = q_acc.pop_front();
                if (cyc !== a) begin
                    errors++;
                    $display("FAIL acc_latch got cyc=%0d want cyc=%0d",
                             cyc, a);
                end
            end
        end
        prev_addr  = int'(cb_addr);
        prev_caddr = int'(coef_addr);
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) tick();
    endtask

    // Drive one sample and record what the sequencer should do with it.
    task automatic send(input logic [17:0] d);
        int n;
        n = cyc;
        din_valid = 1'b1;
        din = d;
        if (n >= free_at) begin
            q_wr.push_back('{d, n + 1});
            for (int k = 0; k < NB; k++)
                q_mac.push_back('{n + 3 + k, k, k == 0, k == NB - 1});
            q_acc.push_back(n + 2 + NB + ML);
            free_at = n + NB + ML + 3;
        end
        tick();
        din_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        free_at = cyc;
        checks++;
        if (ready !== 1'b1 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got ready=%b ovr=%b want 1 0",
                     ready, overrun);
        end
        checks++;
        if (cb_wen !== 1'b0 || cb_din !== 18'h0) begin
            errors++;
            $display("FAIL reset_wr got wen=%b din=%h want 0 0",
                     cb_wen, cb_din);
        end
        checks++;
        if ({mac_en, mac_clr, mac_last, acc_latch} !== 4'b0) begin
            errors++;
            $display("FAIL reset_mac got %b want 0000",
                     {mac_en, mac_clr, mac_last, acc_latch});
        end
        checks++;
        if (cb_addr !== 11'd0 || coef_addr !== 11'd0) begin
            errors++;
            $display("FAIL reset_addr got %0d/%0d want 0/0",
                     cb_addr, coef_addr);
        end
        checks++;
        if (d1_ready !== 1'b1 || bg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_edge_ready got %b%b want 11",
                     d1_ready, bg_ready);
        end
    endtask

    task automatic test_single();
        int n;
        wait_until(free_at);
        n = cyc;
        send(18'h00123);
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL single_busy got ready=%b want 0", ready);
        end
        for (int k = 0; k < NB; k++) begin
            wait_until(n + 2 + k);
            checks++;
            if (int'(cb_addr) !== k || int'(coef_addr) !== k) begin
                errors++;
                $display("FAIL single_addr k=%0d got %0d/%0d want %0d",
                         k, cb_addr, coef_addr, k);
            end
        end
        wait_until(n + 8);
        checks++;
        if (acc_latch !== 1'b1 || ready !== 1'b0) begin
            errors++;
            $display("FAIL single_done got acc=%b ready=%b want 1 0",
                     acc_latch, ready);
        end
        wait_until(n + 9);
        checks++;
        if (ready !== 1'b1 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL single_idle got ready=%b ovr=%b want 1 0",
                     ready, overrun);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        wait_until(free_at);
        n = cyc;
        send(18'h2ABCD);
        wait_until(n + 9);
        send(18'h15432);
        checks++;
        if (cb_wen !== 1'b1 || cb_din !== 18'h15432 ||
            overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept got wen=%b din=%h ovr=%b want 1 15432 0",
                     cb_wen, cb_din, overrun);
        end
        wait_until(free_at);
        n = cyc;
        send(18'h0BEEF);
        wait_until(n + 8);
        send(18'h3FFFF);
        checks++;
        if (overrun !== 1'b1 || ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_drop got ovr=%b ready=%b want 1 1",
                     overrun, ready);
        end
        repeat (4) tick();
    endtask

    task automatic test_overrun_clear();
        int n;
        wait_until(free_at);
        n = cyc;
        send(18'h01111);
        wait_until(n + 2);
        clr_overrun = 1'b1;
        send(18'h02222);
        clr_overrun = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_set_wins got %b want 1", overrun);
        end
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_clear got %b want 0", overrun);
        end
        wait_until(free_at);
    endtask

    task automatic test_reset_mid();
        int n;
        wait_until(free_at);
        n = cyc;
        send(18'h03333);
        wait_until(n + 4);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        while (q_mac.size() > 0 && q_mac[q_mac.size() - 1].c >= n + 5)
            q_mac.delete(q_mac.size() - 1);
        while (q_acc.size() > 0 && q_acc[q_acc.size() - 1] >= n + 5)
            q_acc.delete(q_acc.size() - 1);
        free_at = cyc;
        checks++;
        if (ready !== 1'b1 || mac_en !== 1'b0 || cb_wen !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got ready=%b en=%b wen=%b want 1 0 0",
                     ready, mac_en, cb_wen);
        end
        while (cyc <= n + 12) begin
            checks++;
            if (acc_latch !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_acc cyc=%0d got 1 want 0", cyc);
            end
            tick();
        end
    endtask

    task automatic test_edge_sizes();
        int n, c, acc_c, last_c, beats, bad, maxa;
        n = cyc;
        d1_din = 18'h2AAAA;
        d1_valid = 1'b1;
        tick();
        d1_valid = 1'b0;
        checks++;
        if (d1_wen !== 1'b1 || d1_cbd !== 18'h2AAAA) begin
            errors++;
            $display("FAIL nb1_write got wen=%b din=%h want 1 2aaaa",
                     d1_wen, d1_cbd);
        end
        wait_until(n + 3);
        checks++;
        if ({d1_en, d1_mclr, d1_last, d1_acc} !== 4'b1110) begin
            errors++;
            $display("FAIL nb1_mac got en/clr/last/acc=%b want 1110",
                     {d1_en, d1_mclr, d1_last, d1_acc});
        end
        wait_until(n + 4);
        checks++;
        if (d1_acc !== 1'b1 || d1_en !== 1'b0) begin
            errors++;
            $display("FAIL nb1_acc got acc=%b en=%b want 1 0",
                     d1_acc, d1_en);
        end
        wait_until(n + 5);
        checks++;
        if (d1_ready !== 1'b1 || d1_acc !== 1'b0) begin
            errors++;
            $display("FAIL nb1_idle got ready=%b acc=%b want 1 0",
                     d1_ready, d1_acc);
        end

        n = cyc;
        bg_din = 18'h12345;
        bg_valid = 1'b1;
        tick();
        bg_valid = 1'b0;
        acc_c = -1;
        last_c = -1;
        beats = 0;
        bad = 0;
        maxa = 0;
        for (int i = 0; i < 2200 && acc_c < 0; i++) begin
            c = cyc - n;
            if (c >= 2 && c <= 2049 &&
                (int'(bg_addr) !== c - 2 || int'(bg_caddr) !== c - 2))
                bad++;
            if (int'(bg_addr) > maxa) maxa = int'(bg_addr);
            if (bg_en === 1'b1) beats++;
            if (bg_last === 1'b1) last_c = c;
            if (bg_acc === 1'b1) acc_c = c;
            tick();
        end
        checks++;
        if (bad !== 0 || maxa !== 2047) begin
            errors++;
            $display("FAIL big_sweep got bad=%0d max=%0d want 0 2047",
                     bad, maxa);
        end
        checks++;
        if (beats !== 2048 || last_c !== 2050) begin
            errors++;
            $display("FAIL big_mac got beats=%0d last=%0d want 2048 2050",
                     beats, last_c);
        end
        checks++;
        if (acc_c !== 2052) begin
            errors++;
            $display("FAIL big_acc got cyc=%0d want 2052", acc_c);
        end
    endtask

    initial begin
        reset = 1'b0;
        din_valid = 1'b0;
        din = '0;
        clr_overrun = 1'b0;
        d1_valid = 1'b0;
        d1_din = '0;
        d1_clr = 1'b0;
        bg_valid = 1'b0;
        bg_din = '0;
        bg_clr = 1'b0;

        test_reset();
        test_single();
        test_back_to_back();
        test_overrun_clear();
        test_reset_mid();
        test_edge_sizes();
        repeat (10) tick();

        checks++;
        if (q_wr.size() != 0 || q_mac.size() != 0 || q_acc.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got wr=%0d mac=%0d acc=%0d want 0 0 0",
                     q_wr.size(), q_mac.size(), q_acc.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fir_cb_sequencer.md
Name: fir_cb_sequencer

Overview:
- Controls the 18-bit sample circular buffer for the FIR datapath. Each accepted input sample is written into the buffer.
- It then sweeps the buffer read address across all tap blocks, one block per clock. Each block holds 8 samples.
- In step with the sweep it drives the coefficient ROM address and the MAC control strobes. At the end of the sweep it signals when the accumulated filter output is valid.
- Sits between the sample-input interface, the circular buffer, the coefficient ROM and the MAC array.

Parameters:
- DW, 18, sample width.
- ADDR_W, 11, width of the buffer read address and the coefficient address.
- NBLK, 2048, number of 8-sample blocks per output (taps = 8*NBLK). Legal range 1..2^ADDR_W.
- MAC_LAT, 3, MAC pipeline depth after the last product enters. Must be ≥1.

Ports:
- clock  in  1  master clock, active on rising edge
- reset  in  1  synchronous, active-low reset
- din_valid  in  1  input sample strobe
- din  in  DW  input sample
- clr_overrun  in  1  clears the overrun flag
- ready  out  1  high when a sample can be accepted
- cb_wen  out  1  buffer write enable
- cb_din  out  DW  buffer write data
- cb_addr  out  ADDR_W  buffer relative read address
- coef_addr  out  ADDR_W  coefficient ROM address
- mac_en  out  1  MAC input operands valid
- mac_clr  out  1  first block: load instead of accumulate
- mac_last  out  1  last block
- acc_latch  out  1  one-cycle pulse: accumulator holds the final result
- overrun  out  1  sticky: a sample was dropped

Behaviour:
- Interface (already decided): one clock, named clock. Reset is named reset and is synchronous, active-low.
- All outputs are registered.
- Reset values: state IDLE; ready=1; overrun=0; all other outputs 0. The block counter and the mac_en delay stage are also cleared.
- States and transitions: IDLE -> WRITE -> READ -> DRAIN -> DONE -> IDLE.
- IDLE: ready=1. If din_valid is high at cycle T, the block captures din.
- WRITE (cycle T+1): cb_wen=1 and cb_din=captured sample, for exactly one cycle. ready=0 from T+1 onward.
- READ (cycles T+2 .. T+1+NBLK):
  - cb_addr = coef_addr = k, for k = 0..NBLK-1, one value per cycle.
  - The buffer's write pointer has already advanced, so address 0 returns the newest 8 samples.
  - The block counter is ADDR_W+1 bits wide. Leaving READ is decided by counter==NBLK-1, not by overflow.
- MAC strobes:
  - The buffer and ROM both have a 1-cycle read latency, so the strobes are the READ issue flag delayed by one cycle.
  - mac_en is high on cycles T+3 .. T+2+NBLK.
  - mac_clr is high with the k=0 data only, at T+3.
  - mac_last is high with the k=NBLK-1 data, at T+2+NBLK.
  - When NBLK=1, mac_clr and mac_last are both high in the same cycle.
- DRAIN: MAC_LAT cycles, T+2+NBLK .. T+1+NBLK+MAC_LAT.
- DONE: acc_latch=1 for one cycle at T+2+NBLK+MAC_LAT. State is IDLE and ready=1 at T+3+NBLK+MAC_LAT.
- Required minimum sample spacing: NBLK+MAC_LAT+3 cycles.
- cb_addr and coef_addr hold their last value outside READ. They are don't-care, but must be deterministic.
- Overrun:
  - din_valid while ready=0 drops the sample and sets overrun=1 on the next cycle.
  - clr_overrun clears overrun.
  - If a set and a clear happen in the same cycle, the set wins.
  - The sequence in progress is unaffected.
- din_valid is sampled in the same cycle that acc_latch is pulsed (DONE) → overrun. Acceptance is strictly gated by ready.
- Reset asserted mid-sequence:
  - Takes effect at the next edge; all outputs return to their reset values.
  - No acc_latch is produced.
  - A write already committed to the buffer is not undone.

Decomposition:
- Shared package fir_ctrl_pkg contains:
  - the state enum (IDLE, WRITE, READ, DRAIN, DONE);
  - the DW and ADDR_W defaults;
  - the constant SAMPLES_PER_BLK = 8.
- No sub-module is needed. The delay for the issue flag and mac_clr/mac_last is a single register stage inside the block.

Test Plan (NBLK=4, MAC_LAT=2 unless stated):
- Single sample: din_valid=1 with din=18'h00123 at cycle 0 → cycle 1: cb_wen=1, cb_din=18'h00123. Cycles 2–5: cb_addr=coef_addr=0,1,2,3. mac_en high cycles 3–6, mac_clr at cycle 3, mac_last at cycle 6. acc_latch at cycle 8. ready=1 at cycle 9.
- Back-to-back: second din_valid at cycle 9 → accepted, same timing offset by 9, overrun stays 0. din_valid at cycle 8 instead → dropped, overrun=1 at cycle 9, no extra cb_wen.
- Overrun clear: overrun=1, then clr_overrun and a new illegal din_valid in the same cycle → overrun remains 1. clr_overrun alone → overrun=0 next cycle.
- Reset mid-READ: reset=0 at cycle 4 → cycle 5: ready=1, mac_en=0, cb_wen=0. No acc_latch in cycles 5–12.
- Edge sizes: NBLK=1, MAC_LAT=1 → mac_en, mac_clr and mac_last all high at cycle 3; acc_latch at cycle 4. NBLK=2048 with ADDR_W=11 → cb_addr reaches 2047 with no wrap glitch; acc_latch at cycle 2+2048+MAC_LAT.
